// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared widths, writeback state and held-transaction types
package common_pkg;

    localparam int THREADS_PER_WAVEFRONT = 4;
    localparam int VGPR_DATA_WIDTH       = 32;
    localparam int VGPR_ADDR_WIDTH       = 8;
    localparam int SGPR_DATA_WIDTH       = 32;
    localparam int SGPR_ADDR_WIDTH       = 7;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_LO   = 2'd1,
        WB_HI   = 2'd2
    } wb_state_e;

    // One execute result as held for the LO/HI write cycles
    typedef struct packed {
        logic [THREADS_PER_WAVEFRONT-1:0][2*VGPR_DATA_WIDTH-1:0] vdst;
        logic [THREADS_PER_WAVEFRONT-1:0]                        vdst_wb;
        logic [VGPR_ADDR_WIDTH-1:0]                              vdst_addr;
        logic                                                    vdst_64;
        logic [SGPR_DATA_WIDTH-1:0]                              sdst_lo;
        logic [SGPR_DATA_WIDTH-1:0]                              sdst_hi;
        logic                                                    sdst_wb;
        logic [SGPR_ADDR_WIDTH-1:0]                              sdst_addr;
        logic                                                    sdst_64;
        logic [THREADS_PER_WAVEFRONT-1:0]                        vcc_data;
        logic                                                    vcc_wb;
    } wb_txn_t;

endpackage

// File: rtl/vector_writeback.sv
// rtl/vector_writeback.sv - VGPR/SGPR/VCC writeback stage, 64-bit results split over LO/HI cycles
module vector_writeback
    import common_pkg::*;
(
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic [THREADS_PER_WAVEFRONT-1:0][2*VGPR_DATA_WIDTH-1:0] in_vdst,
    input  logic [THREADS_PER_WAVEFRONT-1:0]                        in_vdst_wb,
    input  logic [VGPR_ADDR_WIDTH-1:0]                              in_vdst_addr,
    input  logic                                                    in_vdst_64,
    input  logic [SGPR_DATA_WIDTH-1:0]                              in_sdst_lo,
    input  logic [SGPR_DATA_WIDTH-1:0]                              in_sdst_hi,
    input  logic                                                    in_sdst_wb,
    input  logic [SGPR_ADDR_WIDTH-1:0]                              in_sdst_addr,
    input  logic                                                    in_sdst_64,
    input  logic [THREADS_PER_WAVEFRONT-1:0]                        in_vcc_data,
    input  logic                                                    in_vcc_wb,
    output logic [THREADS_PER_WAVEFRONT-1:0]                        vgpr_we,
    output logic [VGPR_ADDR_WIDTH-1:0]                              vgpr_waddr,
    output logic [THREADS_PER_WAVEFRONT-1:0][VGPR_DATA_WIDTH-1:0]   vgpr_wdata,
    output logic                                                    sgpr_we,
    output logic [SGPR_ADDR_WIDTH-1:0]                              sgpr_waddr,
    output logic [SGPR_DATA_WIDTH-1:0]                              sgpr_wdata,
    output logic                                                    vcc_we,
    output logic [THREADS_PER_WAVEFRONT-1:0]                        vcc_wdata,
    output logic                                                    wb_done
);

    wb_state_e state_q, state_d;
    wb_txn_t   txn_q, txn_d;
    logic      accept;
    logic      need_hi;

    assign need_hi = (txn_q.vdst_64 & (|txn_q.vdst_wb)) | (txn_q.sdst_64 & txn_q.sdst_wb);

    // Gated by rst so nothing is accepted during the reset cycle
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                WB_IDLE: in_ready = 1'b1;
                WB_HI:   in_ready = 1'b1;
                WB_LO:   in_ready = !(txn_q.vdst_64 | txn_q.sdst_64);
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        if (accept) begin
            txn_d.vdst      = in_vdst;
            txn_d.vdst_wb   = in_vdst_wb;
            txn_d.vdst_addr = in_vdst_addr;
            txn_d.vdst_64   = in_vdst_64;
            txn_d.sdst_lo   = in_sdst_lo;
            txn_d.sdst_hi   = in_sdst_hi;
            txn_d.sdst_wb   = in_sdst_wb;
            txn_d.sdst_addr = in_sdst_addr;
            txn_d.sdst_64   = in_sdst_64;
            txn_d.vcc_data  = in_vcc_data;
            txn_d.vcc_wb    = in_vcc_wb;
        end
        case (state_q)
            WB_IDLE: state_d = accept ? WB_LO : WB_IDLE;
            WB_LO:   state_d = need_hi ? WB_HI : (accept ? WB_LO : WB_IDLE);
            WB_HI:   state_d = accept ? WB_LO : WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_IDLE;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
        end
    end

    // Data and address follow the state; only the enables are qualified
    always_comb begin
        vgpr_we    = '0;
        sgpr_we    = 1'b0;
        vcc_we     = 1'b0;
        wb_done    = 1'b0;
        vgpr_waddr = txn_q.vdst_addr;
        sgpr_waddr = txn_q.sdst_addr;
        sgpr_wdata = txn_q.sdst_lo;
        vcc_wdata  = txn_q.vcc_data;
        for (int i = 0; i < THREADS_PER_WAVEFRONT; i++) begin
            vgpr_wdata[i] = txn_q.vdst[i][VGPR_DATA_WIDTH-1:0];
        end
        if (state_q == WB_HI) begin
            vgpr_waddr = txn_q.vdst_addr + VGPR_ADDR_WIDTH'(1);
            sgpr_waddr = txn_q.sdst_addr + SGPR_ADDR_WIDTH'(1);
            sgpr_wdata = txn_q.sdst_hi;
            for (int i = 0; i < THREADS_PER_WAVEFRONT; i++) begin
                vgpr_wdata[i] = txn_q.vdst[i][2*VGPR_DATA_WIDTH-1:VGPR_DATA_WIDTH];
            end
        end
        if (!rst) begin
            case (state_q)
                WB_LO: begin
                    vgpr_we = txn_q.vdst_wb;
                    sgpr_we = txn_q.sdst_wb;
                    vcc_we  = txn_q.vcc_wb;
                    wb_done = !need_hi;
                end
                WB_HI: begin
                    vgpr_we = txn_q.vdst_64 ? txn_q.vdst_wb : '0;
                    sgpr_we = txn_q.sdst_wb & txn_q.sdst_64;
                    wb_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
